// File: rtl/multi_alarm_unit.sv
// multi_alarm_unit
//    Alarm clock core with NUM_ALARMS editable slots. Keys move a cursor
//    (slot, field), edit the selected field in BCD and toggle a slot's enable.
//    When an enabled slot's time first equals cur_time, the unit rings until
//    it is stopped, it times out, or the slot is disabled.
//
//    Build option: define ALARM_SNOOZE_EN to add the SNOOZE state, the snooze
//    counter and key_snooze handling. Without it, key_snooze is ignored and
//    snoozing is tied low.
//
// Ports
//    clk          system clock, all state on rising edge
//    reset        asynchronous active-low reset
//    sec_tick     one-cycle pulse per second
//    cur_time     BCD hh:mm:ss, {hour, min, sec}, 8 bits each
//    key_*        single-cycle key pulses (left/right/up/down/toggle/snooze/stop)
//    sel_slot     slot under the cursor
//    sel_field    field under the cursor: 0 sec, 1 min, 2 hour
//    sel_time     BCD time of the selected slot
//    alarm_en     per-slot enable bits
//    ringing      high while ringing
//    snoozing     high while snoozing
//    ring_slot    slot that caused the current ring/snooze
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a rising match on an enabled slot
// RINGING | alarm active; ring_cnt counts down seconds to auto-stop
// SNOOZE  | alarm paused; snz_cnt counts down seconds to ring again

module multi_alarm_unit #(
   parameter int NUM_ALARMS       = 4,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int SNOOZE_SEC       = 300
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sec_tick,
   input  logic [23:0]                   cur_time,
   input  logic                          key_left,
   input  logic                          key_right,
   input  logic                          key_up,
   input  logic                          key_down,
   input  logic                          key_toggle,
   input  logic                          key_snooze,
   input  logic                          key_stop,
   output logic [$clog2(NUM_ALARMS)-1:0] sel_slot,
   output logic [1:0]                    sel_field,
   output logic [23:0]                   sel_time,
   output logic [NUM_ALARMS-1:0]         alarm_en,
   output logic                          ringing,
   output logic                          snoozing,
   output logic [$clog2(NUM_ALARMS)-1:0] ring_slot
);

   localparam int SW = $clog2(NUM_ALARMS);
   localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_ALARMS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
      ,
      SNOOZE  = 2'd2
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [23:0]           slot_time [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] match_q, match_d, rise;
   logic                  trig;
   logic [SW-1:0]         trig_slot;
   logic                  en_ring;
   logic [7:0]            ring_cnt;
   logic [7:0]            fld_cur, fld_max, fld_up, fld_dn;
`ifdef ALARM_SNOOZE_EN
   logic [9:0]            snz_cnt;
`else
   logic                  unused_snooze;
   assign unused_snooze = key_snooze;
`endif

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max)             return 8'h00;
      else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
      else                      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if (v == 8'h00)           return max;
      else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
      else                      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign sel_time = slot_time[sel_slot];

   always_comb begin
      case (sel_field)
         2'd0:    fld_cur = sel_time[7:0];
         2'd1:    fld_cur = sel_time[15:8];
         default: fld_cur = sel_time[23:16];
      endcase
      fld_max = (sel_field == 2'd2) ? 8'h23 : 8'h59;
      fld_up  = bcd_inc(fld_cur, fld_max);
      fld_dn  = bcd_dec(fld_cur, fld_max);
   end

   // Editing: one key per cycle, left > right > up > down > toggle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= '0;
         alarm_en  <= '0;
         sel_slot  <= '0;
         sel_field <= '0;
      end else if (key_left) begin
         if (sel_field == 2'd0) begin
            sel_field <= 2'd2;
            sel_slot  <= (sel_slot == '0) ? LAST_SLOT : sel_slot - 1'b1;
         end else begin
            sel_field <= sel_field - 2'd1;
         end
      end else if (key_right) begin
         if (sel_field >= 2'd2) begin
            sel_field <= 2'd0;
            sel_slot  <= (sel_slot == LAST_SLOT) ? '0 : sel_slot + 1'b1;
         end else begin
            sel_field <= sel_field + 2'd1;
         end
      end else if (key_up || key_down) begin
         case (sel_field)
            2'd0:    slot_time[sel_slot][7:0]   <= key_up ? fld_up : fld_dn;
            2'd1:    slot_time[sel_slot][15:8]  <= key_up ? fld_up : fld_dn;
            default: slot_time[sel_slot][23:16] <= key_up ? fld_up : fld_dn;
         endcase
      end else if (key_toggle) begin
         alarm_en[sel_slot] <= ~alarm_en[sel_slot];
      end
   end

   // Match history: only a fresh 0->1 on a registered match starts a ring,
   // so a time that stays equal does not retrigger after stop/timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match_q <= '0;
         match_d <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++)
            match_q[i] <= alarm_en[i] && (slot_time[i] == cur_time);
         match_d <= match_q;
      end
   end

   always_comb begin
      rise      = match_q & ~match_d;
      trig      = |rise;
      trig_slot = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (rise[i]) trig_slot = SW'(i);
   end

   assign en_ring = alarm_en[ring_slot];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (trig) state_nxt = RINGING;
         end
         RINGING: begin
            if (key_stop || !en_ring)                 state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
            else if (key_snooze)                      state_nxt = SNOOZE;
`endif
            else if (sec_tick && ring_cnt <= 8'd1)    state_nxt = IDLE;
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (key_stop || !en_ring)                 state_nxt = IDLE;
            else if (sec_tick && snz_cnt <= 10'd1)    state_nxt = RINGING;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ring_slot <= '0;
         ring_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && trig) ring_slot <= trig_slot;
         // Down-counter reloaded on every entry into RINGING (trigger or snooze end).
         if (state != RINGING && state_nxt == RINGING)
            ring_cnt <= 8'(RING_TIMEOUT_SEC);
         else if (state == RINGING && sec_tick && ring_cnt != 8'd0)
            ring_cnt <= ring_cnt - 8'd1;
      end
   end

`ifdef ALARM_SNOOZE_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snz_cnt <= '0;
      end else if (state == RINGING && state_nxt == SNOOZE) begin
         snz_cnt <= 10'(SNOOZE_SEC);
      end else if (state == SNOOZE && sec_tick && snz_cnt != 10'd0) begin
         snz_cnt <= snz_cnt - 10'd1;
      end
   end
   assign snoozing = (state == SNOOZE);
`else
   assign snoozing = 1'b0;
`endif

   assign ringing = (state == RINGING);

endmodule

// File: tb/tb_multi_alarm_unit.sv
module tb_multi_alarm_unit;

   localparam logic [6:0] K_LEFT  = 7'b1000000;
   localparam logic [6:0] K_RIGHT = 7'b0100000;
   localparam logic [6:0] K_UP    = 7'b0010000;
   localparam logic [6:0] K_DOWN  = 7'b0001000;
   localparam logic [6:0] K_TOG   = 7'b0000100;
   localparam logic [6:0] K_SNZ   = 7'b0000010;
   localparam logic [6:0] K_STOP  = 7'b0000001;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        sec_tick = 1'b0;
   logic [23:0] cur_time = 24'h111111;
   logic        key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
   logic        key_toggle = 1'b0, key_snooze = 1'b0, key_stop = 1'b0;
   logic [1:0]  sel_slot;
   logic [1:0]  sel_field;
   logic [23:0] sel_time;
   logic [3:0]  alarm_en;
   logic        ringing;
   logic        snoozing;
   logic [1:0]  ring_slot;

   int total = 0;
   int bad   = 0;

   multi_alarm_unit dut (
      .clk        (clk),
      .reset      (reset),
      .sec_tick   (sec_tick),
      .cur_time   (cur_time),
      .key_left   (key_left),
      .key_right  (key_right),
      .key_up     (key_up),
      .key_down   (key_down),
      .key_toggle (key_toggle),
      .key_snooze (key_snooze),
      .key_stop   (key_stop),
      .sel_slot   (sel_slot),
      .sel_field  (sel_field),
      .sel_time   (sel_time),
      .alarm_en   (alarm_en),
      .ringing    (ringing),
      .snoozing   (snoozing),
      .ring_slot  (ring_slot)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [6:0] m);
      {key_left, key_right, key_up, key_down, key_toggle, key_snooze, key_stop} = m;
      @(posedge clk);
      #1;
      {key_left, key_right, key_up, key_down, key_toggle, key_snooze, key_stop} = 7'b0;
   endtask

   task automatic press_n(input logic [6:0] m, input int n);
      repeat (n) press(m);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         sec_tick = 1'b1;
         @(posedge clk);
         #1;
         sec_tick = 1'b0;
      end
   endtask

   // Clear match history, then present 00:00:00 so matching slots rise again.
   task automatic retrigger_zero();
      cur_time = 24'h111111;
      step(2);
      cur_time = 24'h000000;
      step(2);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(2);
      total++; if (sel_slot !== 2'd0) begin bad++; $display("FAIL reset_sel_slot got=%0d want=0", sel_slot); end
      total++; if (sel_field !== 2'd0) begin bad++; $display("FAIL reset_sel_field got=%0d want=0", sel_field); end
      total++; if (sel_time !== 24'h0) begin bad++; $display("FAIL reset_sel_time got=%h want=000000", sel_time); end
      total++; if (alarm_en !== 4'b0) begin bad++; $display("FAIL reset_alarm_en got=%b want=0000", alarm_en); end
      total++; if ({ringing, snoozing, ring_slot} !== 4'b0) begin bad++; $display("FAIL reset_fsm got=%b want=0000", {ringing, snoozing, ring_slot}); end
      reset = 1'b1;
      step(1);
   endtask

   task automatic test_basic_ring();
      cur_time = 24'h111111;
      press_n(K_UP, 2);
      total++; if (sel_time !== 24'h000002) begin bad++; $display("FAIL basic_edit got=%h want=000002", sel_time); end
      press(K_TOG);
      total++; if (alarm_en !== 4'b0001) begin bad++; $display("FAIL basic_toggle got=%b want=0001", alarm_en); end
      cur_time = 24'h000002;
      step(1);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", ringing); end
      step(1);
      total++; if (ringing !== 1'b1 || ring_slot !== 2'd0) begin bad++; $display("FAIL basic_ring got=%b/%0d want=1/0", ringing, ring_slot); end
      press(K_STOP);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL basic_stop got=%b want=0", ringing); end
      step(3);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL basic_no_retrigger got=%b want=0", ringing); end
   endtask

   task automatic test_bcd_wrap();
      cur_time = 24'h111111;
      press_n(K_DOWN, 2);
      total++; if (sel_time !== 24'h000000) begin bad++; $display("FAIL bcd_sec_dec got=%h want=000000", sel_time); end
      press(K_DOWN);
      total++; if (sel_time !== 24'h000059) begin bad++; $display("FAIL bcd_sec_wrap_dn got=%h want=000059", sel_time); end
      press(K_RIGHT);
      press(K_DOWN);
      total++; if (sel_time !== 24'h005959) begin bad++; $display("FAIL bcd_min_wrap_dn got=%h want=005959", sel_time); end
      press(K_UP);
      total++; if (sel_time !== 24'h000059) begin bad++; $display("FAIL bcd_min_wrap_up got=%h want=000059", sel_time); end
      press(K_DOWN);
      press(K_RIGHT);
      press(K_DOWN);
      total++; if (sel_time !== 24'h235959) begin bad++; $display("FAIL bcd_hour_wrap_dn got=%h want=235959", sel_time); end
      press(K_UP);
      total++; if (sel_time !== 24'h005959) begin bad++; $display("FAIL bcd_hour_wrap_up got=%h want=005959", sel_time); end
      press_n(K_UP, 10);
      total++; if (sel_time !== 24'h105959) begin bad++; $display("FAIL bcd_hour_carry got=%h want=105959", sel_time); end
      press(K_DOWN);
      total++; if (sel_time !== 24'h095959) begin bad++; $display("FAIL bcd_hour_borrow got=%h want=095959", sel_time); end
   endtask

   task automatic test_slot_nav();
      press_n(K_RIGHT, 9);
      total++; if (sel_slot !== 2'd3 || sel_field !== 2'd2) begin bad++; $display("FAIL nav_to_s3h got=%0d/%0d want=3/2", sel_slot, sel_field); end
      press(K_RIGHT);
      total++; if (sel_slot !== 2'd0 || sel_field !== 2'd0) begin bad++; $display("FAIL nav_right_wrap got=%0d/%0d want=0/0", sel_slot, sel_field); end
      press(K_LEFT);
      total++; if (sel_slot !== 2'd3 || sel_field !== 2'd2) begin bad++; $display("FAIL nav_left_wrap got=%0d/%0d want=3/2", sel_slot, sel_field); end
      press(K_LEFT | K_RIGHT);
      total++; if (sel_slot !== 2'd3 || sel_field !== 2'd1) begin bad++; $display("FAIL nav_left_prio got=%0d/%0d want=3/1", sel_slot, sel_field); end
      press(K_UP | K_DOWN | K_TOG);
      total++; if (sel_time !== 24'h000100 || alarm_en !== 4'b0001) begin bad++; $display("FAIL nav_up_prio got=%h/%b want=000100/0001", sel_time, alarm_en); end
   endtask

   task automatic test_simultaneous();
      press_n(K_RIGHT, 5);
      press(K_TOG);
      press_n(K_RIGHT, 3);
      press(K_TOG);
      total++; if (alarm_en !== 4'b0111 || sel_slot !== 2'd2) begin bad++; $display("FAIL sim_enable got=%b/%0d want=0111/2", alarm_en, sel_slot); end
      cur_time = 24'h000000;
      step(2);
      total++; if (ringing !== 1'b1 || ring_slot !== 2'd1) begin bad++; $display("FAIL sim_lowest got=%b/%0d want=1/1", ringing, ring_slot); end
      tick(59);
      total++; if (ringing !== 1'b1) begin bad++; $display("FAIL sim_tick59 got=%b want=1", ringing); end
      tick(1);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL sim_timeout got=%b want=0", ringing); end
      step(3);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL sim_lost_trigger got=%b want=0", ringing); end
   endtask

   task automatic test_snooze();
      retrigger_zero();
      total++; if (ringing !== 1'b1 || ring_slot !== 2'd1) begin bad++; $display("FAIL snz_ring got=%b/%0d want=1/1", ringing, ring_slot); end
`ifdef ALARM_SNOOZE_EN
      press(K_SNZ);
      total++; if (snoozing !== 1'b1 || ringing !== 1'b0) begin bad++; $display("FAIL snz_enter got=%b/%b want=1/0", snoozing, ringing); end
      tick(299);
      total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL snz_tick299 got=%b want=1", snoozing); end
      tick(1);
      total++; if (ringing !== 1'b1 || snoozing !== 1'b0 || ring_slot !== 2'd1) begin bad++; $display("FAIL snz_expire got=%b/%b/%0d want=1/0/1", ringing, snoozing, ring_slot); end
`else
      press(K_SNZ);
      total++; if (ringing !== 1'b1 || snoozing !== 1'b0) begin bad++; $display("FAIL snz_ignored got=%b/%b want=1/0", ringing, snoozing); end
`endif
      press(K_STOP | K_SNZ);
      total++; if (ringing !== 1'b0 || snoozing !== 1'b0) begin bad++; $display("FAIL snz_stop_wins got=%b/%b want=0/0", ringing, snoozing); end
   endtask

   task automatic test_edit_and_disable();
      retrigger_zero();
      press_n(K_LEFT, 3);
      total++; if (sel_slot !== 2'd1 || sel_field !== 2'd0) begin bad++; $display("FAIL dis_nav got=%0d/%0d want=1/0", sel_slot, sel_field); end
      press(K_UP);
      step(2);
      total++; if (ringing !== 1'b1 || ring_slot !== 2'd1 || sel_time !== 24'h000001) begin bad++; $display("FAIL dis_edit_keeps got=%b/%0d/%h want=1/1/000001", ringing, ring_slot, sel_time); end
      press(K_TOG);
      step(1);
      total++; if (ringing !== 1'b0 || alarm_en !== 4'b0101) begin bad++; $display("FAIL dis_disable got=%b/%b want=0/0101", ringing, alarm_en); end
   endtask

   task automatic test_async_reset();
      retrigger_zero();
      total++; if (ringing !== 1'b1 || ring_slot !== 2'd2) begin bad++; $display("FAIL ar_ring got=%b/%0d want=1/2", ringing, ring_slot); end
`ifdef ALARM_SNOOZE_EN
      press(K_SNZ);
      total++; if (snoozing !== 1'b1) begin bad++; $display("FAIL ar_snooze got=%b want=1", snoozing); end
`endif
      #2;
      reset = 1'b0;
      #1;
      total++; if ({ringing, snoozing, ring_slot} !== 4'b0) begin bad++; $display("FAIL ar_fsm got=%b want=0000", {ringing, snoozing, ring_slot}); end
      total++; if (sel_slot !== 2'd0 || sel_field !== 2'd0 || sel_time !== 24'h0 || alarm_en !== 4'b0) begin bad++; $display("FAIL ar_regs got=%0d/%0d/%h/%b want=0/0/000000/0000", sel_slot, sel_field, sel_time, alarm_en); end
      #3;
      reset = 1'b1;
      step(2);
      total++; if (ringing !== 1'b0) begin bad++; $display("FAIL ar_after got=%b want=0", ringing); end
   endtask

   initial begin
      test_reset();
      test_basic_ring();
      test_bcd_wrap();
      test_slot_nav();
      test_simultaneous();
      test_snooze();
      test_edit_and_disable();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_alarm_unit.md
MULTI_ALARM_UNIT -- requirements
Module: multi_alarm_unit

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4: number of alarm slots, range 2..8.
REQ-002 SHALL have parameter RING_TIMEOUT_SEC, default 60: seconds of ringing before auto-stop, range 1..255.
REQ-003 SHALL have parameter SNOOZE_SEC, default 300: snooze length in seconds, range 1..1023.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sec_tick  input  1  one-cycle pulse per second.
REQ-007 SHALL have port cur_time  input  24  BCD {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}.
REQ-008 SHALL have ports key_left, key_right, key_up, key_down, key_toggle, key_snooze, key_stop  input  1 each  single-cycle key pulses.
REQ-009 SHALL have port sel_slot  output  $clog2(NUM_ALARMS)  slot being edited.
REQ-010 SHALL have port sel_field  output  2  field being edited: 0 sec, 1 min, 2 hour.
REQ-011 SHALL have port sel_time  output  24  BCD time of the selected slot, same packing as cur_time.
REQ-012 SHALL have port alarm_en  output  NUM_ALARMS  per-slot enable bits.
REQ-013 SHALL have port ringing  output  1  high in RINGING.
REQ-014 SHALL have port snoozing  output  1  high in SNOOZE.
REQ-015 SHALL have port ring_slot  output  $clog2(NUM_ALARMS)  slot that triggered the current ring/snooze.

Function
REQ-016 SHALL apply at most one edit key per cycle, priority left > right > up > down > toggle.
REQ-017 SHALL handle key_right as: sel_field+1; from hour, wrap to sec and advance sel_slot mod NUM_ALARMS.
REQ-018 SHALL handle key_left as the exact inverse: from sec, wrap to hour and decrement sel_slot mod NUM_ALARMS.
REQ-019 SHALL BCD-increment the selected field on key_up with wrap sec/min 59->00, hour 23->00, no carry into other fields.
REQ-020 SHALL BCD-decrement the selected field on key_down with wrap 00->59 (sec/min) and 00->23 (hour).
REQ-021 SHALL invert alarm_en[sel_slot] on key_toggle.
REQ-022 SHALL compute match[i] = alarm_en[i] AND slot i time == cur_time, registered every cycle.
REQ-023 SHALL trigger only on a 0->1 edge of a registered match bit, one cycle after that bit rises.
REQ-024 SHALL select the lowest-indexed rising slot on simultaneous triggers.
REQ-025 SHALL use FSM states IDLE, RINGING, SNOOZE.
REQ-026 SHALL move IDLE->RINGING on trigger, latching ring_slot and clearing the ring-seconds counter.
REQ-027 SHALL count sec_tick in RINGING and move to IDLE when the count reaches RING_TIMEOUT_SEC.
REQ-028 SHALL go to IDLE on key_stop in RINGING or SNOOZE; when key_stop and key_snooze coincide, stop wins.
REQ-029 SHALL go RINGING->SNOOZE on key_snooze, loading the snooze counter with SNOOZE_SEC.
REQ-030 SHALL decrement the snooze counter on each sec_tick and move SNOOZE->RINGING at 0, with ring_slot unchanged and the ring counter cleared.
REQ-031 SHALL ignore triggers while in RINGING or SNOOZE; such triggers are lost, not queued.
REQ-032 SHALL return to IDLE when alarm_en[ring_slot] is cleared during RINGING or SNOOZE.
REQ-033 SHALL NOT affect an active ring or snooze when the ringing slot's time is edited.

Reset
REQ-034 SHALL, on reset low, asynchronously clear all slot times to 00:00:00, alarm_en=0, sel_slot=0, sel_field=0, and match history.
REQ-035 SHALL, on reset low, set FSM=IDLE, ringing=0, snoozing=0, ring_slot=0, all counters=0.
REQ-036 SHALL, on reset mid-ring, deassert ringing immediately without waiting for clk.

Configuration
REQ-037 SHALL include the SNOOZE state, snooze counter and key_snooze handling when ALARM_SNOOZE_EN is defined.
REQ-038 SHALL, without ALARM_SNOOZE_EN, ignore key_snooze, omit the SNOOZE state, and tie snoozing to 0; RINGING exits only via stop, timeout, disable or reset.

Verification
REQ-039 SHALL cover: 2x key_up on slot 0 sec field, key_toggle, cur_time 00:00:02 -> ringing=1 two cycles later, ring_slot=0.
REQ-040 SHALL cover: hour=23, key_up -> hour 00; sec=00, key_down -> sec 59; min unchanged in both.
REQ-041 SHALL cover: NUM_ALARMS=4, slot 3 hour field, key_right -> sel_slot=0, sel_field=0; then key_left -> slot 3, hour.
REQ-042 SHALL cover: slots 1 and 2 enabled at the same time, match -> ring_slot=1; 60 sec_ticks -> ringing=0.
REQ-043 SHALL cover, with ALARM_SNOOZE_EN: key_snooze while ringing -> snoozing=1; 300 sec_ticks -> ringing=1; key_stop+key_snooze together -> IDLE.
REQ-044 SHALL cover: reset low during SNOOZE -> all outputs at reset values with no clk edge.
